// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dbnc_pkg.sv
// Shared types and helpers for the debounce block and its synchronizer.
package gf180mcu_fd_sc_mcu9t5v0__dbnc_pkg;

  // STABLE: synchronized input matches Z and the count is zero.
  // QUAL:   synchronized input differs from Z and is being qualified.
  typedef enum logic {
    STABLE = 1'b0,
    QUAL   = 1'b1
  } dbnc_state_e;

  // Counter width: enough bits to hold N-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dbnc_sync2.sv
// Two-flop synchronizer for the asynchronous long-route input.
module gf180mcu_fd_sc_mcu9t5v0__dbnc_sync2 #(
  parameter logic RVAL = 1'b0
) (
  input  logic CLK,
  input  logic RN,
  input  logic D,
  output logic Q
);

  logic s1;

  // First stage may go metastable; second stage gives it a full cycle to settle.
  always_ff @(posedge CLK) begin
    // NOTE: registers use non-blocking assignments so both stages sample
    // their inputs from the same edge; blocking here would collapse the chain.
    if (!RN) begin
      s1 <= RVAL;
      Q  <= RVAL;
    end else begin
      s1 <= D;
      Q  <= s1;
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dbnc_func.sv
// Debouncer: synchronizes I, requires N consecutive mismatching cycles before
// Z follows, and emits registered one-cycle RISE/FALL pulses on Z changes.
module gf180mcu_fd_sc_mcu9t5v0__dbnc_func
  import gf180mcu_fd_sc_mcu9t5v0__dbnc_pkg::*;
#(
  parameter int   N    = 4,
  parameter logic RVAL = 1'b0
) (
`ifdef USE_POWER_PINS
  inout  wire  VDD,
  inout  wire  VSS,
`endif
  input  logic CLK,
  input  logic RN,
  input  logic I,
  output logic Z,
  output logic RISE,
  output logic FALL
);

  localparam int             CW      = cnt_width(N);
  localparam logic [CW-1:0]  CNT_MAX = CW'(N - 1);

  logic            s2;
  dbnc_state_e     state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt, cnt_cur;
  logic            z_nxt, rise_nxt, fall_nxt;

  gf180mcu_fd_sc_mcu9t5v0__dbnc_sync2 #(
    .RVAL (RVAL)
  ) u_sync2 (
    .CLK (CLK),
    .RN  (RN),
    .D   (I),
    .Q   (s2)
  );

  // Next-state, counter and pulse decode from the synchronized input only.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    state_nxt = STABLE;
    cnt_nxt   = '0;
    z_nxt     = Z;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    // STABLE always carries a zero count.
    cnt_cur   = (state == QUAL) ? cnt : '0;
    if (s2 != Z) begin
      if (cnt_cur == CNT_MAX) begin
        z_nxt    = s2;
        rise_nxt = s2;
        fall_nxt = ~s2;
      end else begin
        cnt_nxt   = cnt_cur + 1'b1;
        state_nxt = QUAL;
      end
    end
  end

  // State, count, level and pulse registers; reset overrides any terminal count.
  always_ff @(posedge CLK) begin
    if (!RN) begin
      state <= STABLE;
      cnt   <= '0;
      Z     <= RVAL;
      RISE  <= 1'b0;
      FALL  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      Z     <= z_nxt;
      RISE  <= rise_nxt;
      FALL  <= fall_nxt;
    end
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__dbnc_func.sv
// Directed bench for the debouncer: latency, glitch rejection, reset
// precedence, reset value and a long-N stress run.
module tb_gf180mcu_fd_sc_mcu9t5v0__dbnc_func;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // a: N=4 RVAL=0   b: N=1 RVAL=0   c: N=4 RVAL=1   d: N=65535 RVAL=0
  logic rn_a = 1'b0, i_a = 1'b0, z_a, rise_a, fall_a;
  logic rn_b = 1'b0, i_b = 1'b0, z_b, rise_b, fall_b;
  logic rn_c = 1'b0, i_c = 1'b0, z_c, rise_c, fall_c;
  logic rn_d = 1'b0, i_d = 1'b0, z_d, rise_d, fall_d;

  gf180mcu_fd_sc_mcu9t5v0__dbnc_func #(.N(4), .RVAL(1'b0)) dut_a (
    .CLK(clk), .RN(rn_a), .I(i_a), .Z(z_a), .RISE(rise_a), .FALL(fall_a));
  gf180mcu_fd_sc_mcu9t5v0__dbnc_func #(.N(1), .RVAL(1'b0)) dut_b (
    .CLK(clk), .RN(rn_b), .I(i_b), .Z(z_b), .RISE(rise_b), .FALL(fall_b));
  gf180mcu_fd_sc_mcu9t5v0__dbnc_func #(.N(4), .RVAL(1'b1)) dut_c (
    .CLK(clk), .RN(rn_c), .I(i_c), .Z(z_c), .RISE(rise_c), .FALL(fall_c));
  gf180mcu_fd_sc_mcu9t5v0__dbnc_func #(.N(65535), .RVAL(1'b0)) dut_d (
    .CLK(clk), .RN(rn_d), .I(i_d), .Z(z_d), .RISE(rise_d), .FALL(fall_d));

  // Advance past one rising edge; outputs then reflect that edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a(input int cycles);
    rn_a = 1'b0;
    i_a  = 1'b0;
    for (int k = 0; k < cycles; k++) step();
    rn_a = 1'b1;
  endtask

  task automatic test_reset();
    reset_a(3);
    n_cmp++;
    if ({z_a, rise_a, fall_a} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_a zrf=%b want 000", {z_a, rise_a, fall_a});
    end
    n_cmp++;
    if (dut_a.cnt !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_a_cnt cnt=%0d want 0", dut_a.cnt);
    end
  endtask

  // Step up held from edge 0: Z and RISE at edge 5, then glitch-rejected fall.
  task automatic test_rise_latency();
    logic [2:0] exp;
    i_a = 1'b1;
    for (int e = 0; e < 8; e++) begin
      step();
      exp = {(e >= 5), (e == 5), 1'b0};
      n_cmp++;
      if ({z_a, rise_a, fall_a} !== exp) begin
        n_bad++;
        $display("FAIL rise_lat edge=%0d zrf=%b want %b", e, {z_a, rise_a, fall_a}, exp);
      end
    end
  endtask

  task automatic test_glitch();
    logic [2:0] exp;
    // 0 for 3 cycles, 1 for 1 cycle: Z must hold at 1 throughout.
    for (int g = 0; g < 4; g++) begin
      i_a = (g == 3);
      step();
      n_cmp++;
      if ({z_a, rise_a, fall_a} !== 3'b100) begin
        n_bad++;
        $display("FAIL glitch g=%0d zrf=%b want 100", g, {z_a, rise_a, fall_a});
      end
    end
    i_a = 1'b0;
    for (int e = 0; e < 8; e++) begin
      step();
      exp = {(e < 5), 1'b0, (e == 5)};
      n_cmp++;
      if ({z_a, rise_a, fall_a} !== exp) begin
        n_bad++;
        $display("FAIL glitch_fall edge=%0d zrf=%b want %b", e, {z_a, rise_a, fall_a}, exp);
      end
    end
  endtask

  // Half-period 3 with N=4: qualification never completes.
  task automatic test_back_to_back();
    reset_a(2);
    for (int e = 0; e < 30; e++) begin
      i_a = ((e / 3) % 2) == 1;
      step();
      n_cmp++;
      if ({z_a, rise_a, fall_a} !== 3'b000) begin
        n_bad++;
        $display("FAIL fast_toggle edge=%0d zrf=%b want 000", e, {z_a, rise_a, fall_a});
      end
    end
  endtask

  // Reset one edge before terminal, then a full re-qualification.
  task automatic test_reset_mid_qual();
    logic [2:0] exp;
    reset_a(2);
    i_a = 1'b1;
    for (int e = 0; e < 4; e++) step();
    rn_a = 1'b0;
    step();
    n_cmp++;
    if ({z_a, rise_a, fall_a, dut_a.cnt} !== 5'b000_00) begin
      n_bad++;
      $display("FAIL mid_qual_rst zrf_cnt=%b want 00000", {z_a, rise_a, fall_a, dut_a.cnt});
    end
    rn_a = 1'b1;
    for (int r = 0; r < 7; r++) begin
      step();
      exp = {(r >= 5), (r == 5), 1'b0};
      n_cmp++;
      if ({z_a, rise_a, fall_a} !== exp) begin
        n_bad++;
        $display("FAIL post_rst edge=%0d zrf=%b want %b", r, {z_a, rise_a, fall_a}, exp);
      end
    end
  endtask

  // Reset asserted on the very edge that would be terminal.
  task automatic test_reset_at_terminal();
    reset_a(2);
    i_a = 1'b1;
    for (int e = 0; e < 5; e++) step();
    rn_a = 1'b0;
    step();
    n_cmp++;
    if ({z_a, rise_a, fall_a} !== 3'b000) begin
      n_bad++;
      $display("FAIL rst_terminal zrf=%b want 000", {z_a, rise_a, fall_a});
    end
    rn_a = 1'b1;
    step();
    n_cmp++;
    if ({z_a, rise_a, fall_a} !== 3'b000) begin
      n_bad++;
      $display("FAIL rst_release zrf=%b want 000", {z_a, rise_a, fall_a});
    end
  endtask

  function automatic logic ival_b(input int e);
    return (e >= 0) ? (((e / 3) % 2) == 1) : 1'b0;
  endfunction

  // N=1: Z follows I two edges later, one pulse per transition.
  task automatic test_n1_follow();
    logic [2:0] exp;
    rn_b = 1'b0;
    i_b  = 1'b0;
    step();
    step();
    rn_b = 1'b1;
    for (int e = 0; e < 24; e++) begin
      i_b = ival_b(e);
      step();
      exp = {ival_b(e - 2),
             ival_b(e - 2) & ~ival_b(e - 3),
             ~ival_b(e - 2) & ival_b(e - 3)};
      n_cmp++;
      if ({z_b, rise_b, fall_b} !== exp) begin
        n_bad++;
        $display("FAIL n1_follow edge=%0d zrf=%b want %b", e, {z_b, rise_b, fall_b}, exp);
      end
    end
  endtask

  // RVAL=1 with I=1: Z is 1 straight out of reset and never pulses.
  task automatic test_rval1();
    rn_c = 1'b0;
    i_c  = 1'b1;
    step();
    n_cmp++;
    if ({z_c, rise_c, fall_c} !== 3'b100) begin
      n_bad++;
      $display("FAIL rval1_rst zrf=%b want 100", {z_c, rise_c, fall_c});
    end
    rn_c = 1'b1;
    for (int e = 0; e < 10; e++) begin
      step();
      n_cmp++;
      if ({z_c, rise_c, fall_c} !== 3'b100) begin
        n_bad++;
        $display("FAIL rval1_hold edge=%0d zrf=%b want 100", e, {z_c, rise_c, fall_c});
      end
    end
  endtask

  // N=65535 with random toggles far shorter than N: Z constant, cnt bounded.
  task automatic test_long_n();
    int run;
    int cnt_over = 0;
    int z_moves  = 0;
    rn_d = 1'b0;
    i_d  = 1'b0;
    step();
    step();
    rn_d = 1'b1;
    run = 0;
    for (int e = 0; e < 3000; e++) begin
      if (run == 0) begin
        i_d = ~i_d;
        run = $urandom_range(200, 1);
      end
      run--;
      step();
      if (dut_d.cnt > 16'd65534) cnt_over++;
      if ({z_d, rise_d, fall_d} !== 3'b000) z_moves++;
    end
    n_cmp++;
    if (z_moves != 0) begin
      n_bad++;
      $display("FAIL long_n_z cycles_changed=%0d want 0", z_moves);
    end
    n_cmp++;
    if (cnt_over != 0) begin
      n_bad++;
      $display("FAIL long_n_cnt over_max=%0d want 0", cnt_over);
    end
  endtask

  initial begin
    test_reset();
    test_rise_latency();
    test_glitch();
    test_back_to_back();
    test_reset_mid_qual();
    test_reset_at_terminal();
    test_n1_follow();
    test_rval1();
    test_long_n();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
